dmx_rx_decoder: RTL and testbench
=================================

DMX_RX_DECODER -- requirements
Module: dmx_rx_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 20_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 250_000, DMX slot bit rate.
REQ-003 SHALL have parameter MAX_SLOTS, default 512, highest data slot number written.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 dmx_rx  in  1  asynchronous DMX line from the RS-485 receiver; idle high.
REQ-008 wr_en  out  1  one-cycle write strobe toward EBR port B.
REQ-009 wr_addr  out  10  slot number minus 1, range 0..MAX_SLOTS-1.
REQ-010 wr_data  out  8  received slot value.
REQ-011 frame_done  out  1  one-cycle pulse at end of a frame with start code 0x00.
REQ-012 slot_count  out  10  data slots received in the last completed frame; held until the next frame_done.
REQ-013 err_framing  out  1  one-cycle pulse on a stop-bit error that is not a break.

Function
REQ-014 SHALL resynchronise dmx_rx through 2 flip-flops; all decisions use the synchronised value rxs.
REQ-015 SHALL derive BIT_T = CLK_FREQ/BAUD_RATE (80), HALF = BIT_T/2, BRK_MIN = CLK_FREQ/1e6*88 (1760) and MAB_MIN = CLK_FREQ/1e6*8 (160) cycles.
REQ-016 SHALL implement states IDLE, BRK, MAB, START, DATA, STOP and GAP.
REQ-017 IDLE: rxs=0 -> BRK with cnt=0.
REQ-018 BRK: count low cycles. rxs=1 with cnt>=BRK_MIN -> MAB with cnt=0. rxs=1 with cnt<BRK_MIN -> IDLE; no outputs change.
REQ-019 MAB: count high cycles. rxs=0 with cnt>=MAB_MIN -> START with slot=0 and cnt=0. rxs=0 with cnt<MAB_MIN -> BRK with cnt=0.
REQ-020 START: at cnt=HALF, rxs=0 -> DATA; rxs=1 -> IDLE (glitch; frame dropped, no pulses).
REQ-021 DATA: sample 8 bits LSB-first, one every BIT_T cycles after the start-bit mid-sample; then -> STOP.
REQ-022 STOP: sample at the next mid-bit.
  - rxs=1: byte accepted -> GAP.
  - rxs=0 and byte=0x00: treated as the start of a break -> BRK, with cnt preloaded to 9*BIT_T+HALF. If slot>=2 and start code was 0x00, pulse frame_done.
  - rxs=0 and byte!=0x00: pulse err_framing -> IDLE; partial frame is not reported by frame_done.
REQ-023 GAP: wait while rxs=1; rxs=0 -> START with cnt=0. There is no maximum inter-slot time.
REQ-024 Slot 0 is the start code and is latched internally, never written.
REQ-025 Accepted slot n (1..MAX_SLOTS) with start code 0x00 -> the cycle after the stop-bit sample, wr_en=1, wr_addr=n-1, wr_data=byte. Non-zero start code -> no writes for the whole frame.
REQ-026 When slot MAX_SLOTS is accepted with start code 0x00:
  - pulse frame_done in the same cycle as its wr_en;
  - load slot_count=MAX_SLOTS;
  - -> IDLE; further slots are ignored until the next break.
REQ-027 Whenever frame_done pulses, slot_count SHALL be loaded with the number of data slots accepted (slot-1).
REQ-028 slot counter SHALL saturate; wr_addr never exceeds MAX_SLOTS-1.
REQ-029 wr_en, frame_done and err_framing SHALL never be high for more than one consecutive cycle per event.
REQ-030 A valid break detected in any state restarts the frame. Previously written EBR data is kept, not cleared.

Reset
REQ-031 rst=1 -> state IDLE, all counters 0, synchronisers 1, wr_en/frame_done/err_framing 0, wr_addr 0, wr_data 0, slot_count 0.
REQ-032 rst asserted mid-frame aborts it with no pulses. Decoding after release waits for a full new break.

Verification
REQ-033 Break 100us, MAB 12us, slots 0x00,0x11,0x22,0x33 (2 stop bits), then new break -> 3 writes (addr 0..2, data 11/22/33), one cycle after each stop-bit sample. frame_done pulses with slot_count=3.
REQ-034 Full frame of 512 slots, slot n = n[7:0], start code 0x00 -> 512 writes; frame_done coincides with the addr-511 write; slot_count=512; extra trailing slots are ignored.
REQ-035 Start code 0xCC followed by 10 slots -> no wr_en, no frame_done.
REQ-036 Low pulse of 50us then high -> no state change beyond IDLE; a following valid frame decodes normally.
REQ-037 Slot 0x55 with stop bit driven low -> err_framing pulse, no write, IDLE. A 20-cycle low glitch in GAP -> START rejects it and returns to IDLE.
REQ-038 rst asserted after slot 5 of a frame -> outputs reach reset values next cycle. The following break plus 2-slot frame writes addr 0..1 and gives slot_count=2.

Source files
------------

// File: rtl/dmx_rx_decoder.sv
// DMX512 receive decoder: detects break / mark-after-break, deserialises
// 8N2 slots from the resynchronised line and streams data slots of
// start-code-0x00 frames into a slot-indexed memory write port.
module dmx_rx_decoder #(
    parameter int unsigned CLK_FREQ  = 20_000_000,
    parameter int unsigned BAUD_RATE = 250_000,
    parameter int unsigned MAX_SLOTS = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmx_rx,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic [9:0] slot_count,
    output logic       err_framing
);

    localparam int unsigned BIT_T     = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF      = BIT_T / 2;
    localparam int unsigned CYC_US    = CLK_FREQ / 1_000_000;
    localparam int unsigned BRK_MIN   = CYC_US * 88;
    localparam int unsigned MAB_MIN   = CYC_US * 8;
    // Low time already elapsed when a 0x00 byte with a low stop bit is seen
    localparam int unsigned BRK_PRE   = 9 * BIT_T + HALF;
    localparam int unsigned CNT_MAX_A = (BRK_MIN > BRK_PRE) ? BRK_MIN : BRK_PRE;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > BIT_T) ? CNT_MAX_A : BIT_T;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned SLOT_W    = $clog2(MAX_SLOTS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BRK   = 3'd1,
        S_MAB   = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          sync;
    logic                rxs;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic [2:0]          bit_idx;
    logic [2:0]          bit_idx_next;
    logic [7:0]          shreg;
    logic [7:0]          shreg_next;
    logic [SLOT_W-1:0]   slot;
    logic [SLOT_W-1:0]   slot_next;
    logic [7:0]          start_code;
    logic [7:0]          start_code_next;
    logic                wr_en_next;
    logic [9:0]          wr_addr_next;
    logic [7:0]          wr_data_next;
    logic                frame_done_next;
    logic [9:0]          slot_count_next;
    logic                err_framing_next;

    logic                brk_ok;
    logic                mab_ok;
    logic                half_tick;
    logic                bit_tick;
    logic                byte_zero;
    logic                sc_zero;
    logic                last_slot;
    logic                has_data;

    assign rxs       = sync[1];
    assign cnt_inc   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
    assign brk_ok    = (cnt >= CNT_W'(BRK_MIN));
    assign mab_ok    = (cnt >= CNT_W'(MAB_MIN));
    assign half_tick = (cnt == CNT_W'(HALF));
    assign bit_tick  = (cnt == CNT_W'(BIT_T - 1));
    assign byte_zero = (shreg == 8'h00);
    assign sc_zero   = (start_code == 8'h00);
    assign last_slot = (slot == SLOT_W'(MAX_SLOTS));
    assign has_data  = (slot >= SLOT_W'(2));

    // Two-flop resynchroniser for the asynchronous line, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], dmx_rx};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rxs) state_next = S_BRK;
            end
            S_BRK: begin
                if (rxs) state_next = brk_ok ? S_MAB : S_IDLE;
            end
            S_MAB: begin
                if (!rxs) state_next = mab_ok ? S_START : S_BRK;
            end
            S_START: begin
                if (half_tick) state_next = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (rxs) begin
                        state_next = (last_slot && sc_zero) ? S_IDLE : S_GAP;
                    end else begin
                        state_next = byte_zero ? S_BRK : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (!rxs) state_next = S_START;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        cnt_next         = cnt_inc;
        bit_idx_next     = bit_idx;
        shreg_next       = shreg;
        slot_next        = slot;
        start_code_next  = start_code;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr;
        wr_data_next     = wr_data;
        frame_done_next  = 1'b0;
        slot_count_next  = slot_count;
        err_framing_next = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
            end
            S_BRK: begin
                if (rxs) cnt_next = '0;
            end
            S_MAB: begin
                if (!rxs) begin
                    cnt_next = '0;
                    if (mab_ok) slot_next = '0;
                end
            end
            S_START: begin
                if (half_tick) begin
                    cnt_next     = '0;
                    bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_next     = '0;
                    shreg_next   = {rxs, shreg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (rxs) begin
                        if (slot == '0) begin
                            start_code_next = shreg;
                        end else if (sc_zero) begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = 10'(slot - SLOT_W'(1));
                            wr_data_next = shreg;
                            if (last_slot) begin
                                frame_done_next = 1'b1;
                                slot_count_next = 10'(MAX_SLOTS);
                            end
                        end
                        if (!last_slot) slot_next = slot + SLOT_W'(1);
                    end else if (byte_zero) begin
                        cnt_next = CNT_W'(BRK_PRE);
                        if (has_data && sc_zero) begin
                            frame_done_next = 1'b1;
                            slot_count_next = 10'(slot - SLOT_W'(1));
                        end
                    end else begin
                        err_framing_next = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!rxs) cnt_next = '0;
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            slot        <= '0;
            start_code  <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            slot_count  <= '0;
            err_framing <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            shreg       <= shreg_next;
            slot        <= slot_next;
            start_code  <= start_code_next;
            wr_en       <= wr_en_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            frame_done  <= frame_done_next;
            slot_count  <= slot_count_next;
            err_framing <= err_framing_next;
        end
    end

endmodule

// File: tb/tb_dmx_rx_decoder.sv
// Scoreboard bench for dmx_rx_decoder: a line driver serialises DMX frames,
// a frame-level model predicts writes / frame_done / err_framing with their
// cycle, and an independent monitor pops and compares every output event.
// A 2 MHz clock keeps the 512-slot frame within a short run.
`timescale 1ns/1ps
module tb_dmx_rx_decoder;

    localparam int unsigned CLK_FREQ  = 2_000_000;
    localparam int unsigned BAUD_RATE = 250_000;
    localparam int unsigned MAX_SLOTS = 512;
    localparam int unsigned BIT_T     = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF      = BIT_T / 2;
    localparam int unsigned US        = CLK_FREQ / 1_000_000;
    // Stop-bit edge to visible strobe: 2 sync stages, 1 cycle to enter START,
    // mid-bit at HALF, registered output one cycle after the sample.
    localparam int unsigned LAT       = HALF + 4;

    localparam int K_WR  = 0;
    localparam int K_FD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int     kind;
        int     addr;
        int     data;
        int     count;
        longint cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dmx_rx;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic [9:0] slot_count;
    logic       err_framing;

    ev_t    exp_q[$];
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    // Frame-level reference model state
    bit     frame_live = 1'b0;
    int     slot_no = 0;
    int     sc = 0;
    int     last_count = 0;

    dmx_rx_decoder #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .MAX_SLOTS(MAX_SLOTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dmx_rx     (dmx_rx),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .slot_count (slot_count),
        .err_framing(err_framing)
    );

    always #250 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_WR:    return "wr_en";
            K_FD:    return "frame_done";
            default: return "err_framing";
        endcase
    endfunction

    task automatic push(input int kind, input int addr, input int data, input int count, input longint t);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.count = count; e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Accepted slot with a good stop bit
    task automatic model_slot(input int b, input longint t);
        if (!frame_live) return;
        if (slot_no == 0) begin
            sc = b;
        end else if (sc == 0) begin
            push(K_WR, slot_no - 1, b, 0, t);
            if (slot_no == MAX_SLOTS) begin
                push(K_FD, 0, 0, MAX_SLOTS, t);
                last_count = MAX_SLOTS;
                frame_live = 1'b0;
            end
        end
        if (slot_no < MAX_SLOTS) slot_no++;
    endtask

    // Non-zero byte whose stop bit is low
    task automatic model_bad_stop(input int b, input longint t);
        if (frame_live && b != 0) begin
            push(K_ERR, 0, 0, 0, t);
            frame_live = 1'b0;
        end
    endtask

    // A valid break closes a live start-code-0x00 frame holding data slots
    task automatic model_break(input longint t_start);
        if (frame_live && sc == 0 && slot_no >= 2) begin
            push(K_FD, 0, 0, slot_no - 1, t_start + 9 * BIT_T + LAT);
            last_count = slot_no - 1;
        end
    endtask

    // All line drivers start and end on a falling clock edge
    task automatic hold(input logic v, input int n);
        dmx_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int nstop);
        longint stop_cyc;
        hold(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_T);
        stop_cyc = cyc;
        if (stop_ok) begin
            model_slot(int'(b), stop_cyc + LAT);
            hold(1'b1, nstop * BIT_T);
        end else begin
            model_bad_stop(int'(b), stop_cyc + LAT);
            hold(1'b0, BIT_T);
            hold(1'b1, nstop * BIT_T);
        end
    endtask

    task automatic send_break(input int brk_us, input int mab_us);
        model_break(cyc);
        hold(1'b0, brk_us * US);
        hold(1'b1, mab_us * US);
        frame_live = 1'b1;
        slot_no = 0;
    endtask

    task automatic send_frame(input logic [7:0] sc_b, input int n, input int nstop, input int gap_max);
        send_byte(sc_b, 1'b1, nstop);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, int'($urandom_range(gap_max, 0)));
            send_byte(8'($urandom), 1'b1, nstop);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted event
    task automatic check_ev(input int kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d (addr %0d data %0h count %0d), required none",
                     kname(kind), cyc, wr_addr, wr_data, slot_count);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind == K_WR && (int'(wr_addr) != e.addr || int'(wr_data) != e.data)) ||
            (kind == K_FD && int'(slot_count) != e.count)) begin
            n_fail++;
            $display("FAIL event_%s: got %s@%0d addr %0d data %0h count %0d, required %s@%0d addr %0d data %0h count %0d",
                     kname(kind), kname(kind), cyc, wr_addr, wr_data, slot_count,
                     kname(e.kind), e.cyc, e.addr, e.data, e.count);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (wr_en)       check_ev(K_WR);
            if (frame_done)  check_ev(K_FD);
            if (err_framing) check_ev(K_ERR);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, longint'(wr_en), 0);
        chk({tag, "_wr_addr"}, longint'(wr_addr), 0);
        chk({tag, "_wr_data"}, longint'(wr_data), 0);
        chk({tag, "_frame_done"}, longint'(frame_done), 0);
        chk({tag, "_slot_count"}, longint'(slot_count), 0);
        chk({tag, "_err_framing"}, longint'(err_framing), 0);
    endtask

    initial begin
        rst = 1'b1;
        dmx_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        hold(1'b1, 20);
        check_reset_outputs("post_reset");

        // Short 50us low is not a break; then the reference 4-slot frame
        hold(1'b0, 50 * US);
        hold(1'b1, 40);
        send_break(100, 12);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h11, 1'b1, 2);
        send_byte(8'h22, 1'b1, 2);
        send_byte(8'h33, 1'b1, 2);
        send_break(100, 12);
        chk("frame4_slot_count", longint'(slot_count), 3);

        // Random frames: empty frame, one-slot frame, mixed lengths and timing
        for (int k = 0; k < 6; k++) begin
            int n;
            logic [7:0] scb;
            n = (k == 0) ? 0 : (k == 1) ? 1 : int'($urandom_range(24, 2));
            scb = (k == 4) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(scb, n, int'($urandom_range(3, 1)), 12);
            hold(1'b1, int'($urandom_range(30, 0)));
            send_break(int'($urandom_range(150, 90)), int'($urandom_range(20, 9)));
        end
        chk("random_slot_count", longint'(slot_count), longint'(last_count));

        // Non-zero start code: no writes, no frame_done, count held
        send_byte(8'hCC, 1'b1, 2);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 2);
        send_break(100, 12);
        chk("altsc_slot_count_held", longint'(slot_count), longint'(last_count));

        // Framing error on 0x55, then glitch rejection in the inter-slot gap
        send_frame(8'h00, 3, 2, 4);
        send_byte(8'h55, 1'b0, 2);
        send_byte(8'h44, 1'b1, 2);
        send_break(100, 12);
        send_frame(8'h00, 2, 2, 4);
        hold(1'b0, 3);
        hold(1'b1, 2 * BIT_T);
        frame_live = 1'b0;
        send_byte(8'h66, 1'b1, 2);
        send_byte(8'h77, 1'b1, 2);
        send_break(100, 12);
        chk("glitch_slot_count_held", longint'(slot_count), longint'(last_count));

        // Reset after slot 5 aborts the frame; decoding waits for a new break
        send_frame(8'h00, 5, 2, 4);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        frame_live = 1'b0;
        last_count = 0;
        hold(1'b1, 10);
        send_byte(8'h5A, 1'b1, 2);
        send_byte(8'hA5, 1'b1, 2);
        send_break(100, 12);
        send_frame(8'h00, 2, 2, 4);
        send_break(100, 12);
        chk("after_reset_slot_count", longint'(slot_count), 2);

        // Full-length frame with trailing slots that must be ignored
        send_byte(8'h00, 1'b1, 1);
        for (int n = 1; n <= MAX_SLOTS + 3; n++) begin
            hold(1'b1, int'($urandom_range(2, 0)));
            send_byte(8'(n), 1'b1, 1);
        end
        hold(1'b1, 20);
        chk("full_slot_count", longint'(slot_count), MAX_SLOTS);
        send_break(100, 12);
        hold(1'b1, 40);
        chk("full_slot_count_held", longint'(slot_count), MAX_SLOTS);

        // Drain outstanding predictions within a bounded wait
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_events", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
